// File: rtl/sobel_dsm_writer.sv
// sobel_dsm_writer: writes one 64-byte status line to the host DSM area over CCI-P channel 1.
//
// A single-cycle report_req captures a status code, payload, the DSM base address and a
// snapshot of a free-running 64-bit cycle counter. The block then issues one WRLINE_I,
// waits for the matching write response (bounded by RSP_TIMEOUT) and pulses done.
//
// Ports
//   clk          single clock
//   reset        asynchronous active-high reset
//   hc_dsm_base  DSM cache-line address from host software (0 = not programmed)
//   report_req   one-cycle request to write a status line
//   report_code  status code sampled with report_req
//   report_data  status payload sampled with report_req
//   c1TxAlmFull  channel-1 almost-full back-pressure
//   c1Rx         channel-1 write response channel
//   c1Tx         channel-1 write request channel
//   busy         high while a report is in flight
//   done         one-cycle pulse when the write is acknowledged
//   error        sticky: response timeout or report with null base
//   overrun      sticky: report_req dropped while busy

// Minimal CCI-P channel-1 type subset used by this block.
package ccip_if_pkg;
    typedef logic [63:0]  t_hc_address;
    typedef logic [41:0]  t_ccip_clAddr;
    typedef logic [15:0]  t_ccip_mdata;
    typedef logic [511:0] t_ccip_clData;

    typedef enum logic [1:0] {
        eVC_VA  = 2'h0,
        eVC_VL0 = 2'h1,
        eVC_VH0 = 2'h2,
        eVC_VH1 = 2'h3
    } t_ccip_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'h0,
        eCL_LEN_2 = 2'h1,
        eCL_LEN_4 = 2'h3
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_ccip_c1_req;

    typedef enum logic [3:0] {
        eRSP_WRLINE  = 4'h0,
        eRSP_WRFENCE = 4'h4,
        eRSP_INTR    = 4'h6
    } t_ccip_c1_rsp;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic         sop;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         hit_miss;
        logic         format;
        logic [1:0]   cl_num;
        t_ccip_c1_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;
endpackage

module sobel_dsm_writer
    import ccip_if_pkg::*;
#(
    parameter logic [15:0] MDATA_TAG   = 16'hD5A0,
    parameter int unsigned RSP_TIMEOUT = 4096
) (
    input  logic           clk,
    input  logic           reset,
    input  t_hc_address    hc_dsm_base,
    input  logic           report_req,
    input  logic [31:0]    report_code,
    input  logic [63:0]    report_data,
    input  logic           c1TxAlmFull,
    input  t_if_ccip_c1_Rx c1Rx,
    output t_if_ccip_c1_Tx c1Tx,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic           overrun
);
    localparam int unsigned     TmoW    = $clog2(RSP_TIMEOUT + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(RSP_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRsp, StDone} state_e;

    state_e          state_q, state_d;
    logic [63:0]     cnt_q;
    logic [31:0]     seq_q, seq_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;
    logic            error_q, overrun_q;
    logic [31:0]     code_q;
    logic [63:0]     data_q;
    logic [41:0]     base_q;
    logic [63:0]     snap_q;

    logic latch;
    logic error_set;
    logic rsp_ok;

    assign rsp_ok = c1Rx.rspValid && (c1Rx.hdr.resp_type == eRSP_WRLINE) &&
                    (c1Rx.hdr.mdata == MDATA_TAG);

    // Response header fields this block does not need.
    logic unused_rsp_bits;
    assign unused_rsp_bits = ^{c1Rx.hdr.vc_used, c1Rx.hdr.hit_miss, c1Rx.hdr.format,
                               c1Rx.hdr.cl_num};

    // valid_q is loaded from the almost-full value of the preceding cycle, so the request
    // goes out in the cycle right after report_req when there is no back-pressure.
    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        tmo_d     = tmo_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        latch     = 1'b0;
        error_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (report_req) begin
                    if (hc_dsm_base != '0) begin
                        latch   = 1'b1;
                        valid_d = !c1TxAlmFull;
                        state_d = StIssue;
                    end else begin
                        error_set = 1'b1;
                    end
                end
            end
            StIssue: begin
                if (valid_q) begin
                    state_d = StWaitRsp;
                    tmo_d   = '0;
                end else begin
                    valid_d = !c1TxAlmFull;
                end
            end
            StWaitRsp: begin
                // A response in the final allowed cycle wins over the timeout.
                if (rsp_ok) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    seq_d   = seq_q + 32'd1;
                end else if (tmo_q == TmoLast) begin
                    state_d   = StIdle;
                    error_set = 1'b1;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            seq_q     <= '0;
            tmo_q     <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            overrun_q <= 1'b0;
            code_q    <= '0;
            data_q    <= '0;
            base_q    <= '0;
            snap_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_q + 64'd1;
            seq_q   <= seq_d;
            tmo_q   <= tmo_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            if (error_set) begin
                error_q <= 1'b1;
            end
            if (report_req && (state_q != StIdle)) begin
                overrun_q <= 1'b1;
            end
            if (latch) begin
                code_q <= report_code;
                data_q <= report_data;
                base_q <= hc_dsm_base[41:0];
                snap_q <= cnt_q;
            end
        end
    end

    always_comb begin
        c1Tx                  = '0;
        c1Tx.hdr.vc_sel       = eVC_VA;
        c1Tx.hdr.sop          = 1'b1;
        c1Tx.hdr.cl_len       = eCL_LEN_1;
        c1Tx.hdr.req_type     = eREQ_WRLINE_I;
        c1Tx.hdr.address      = base_q;
        c1Tx.hdr.mdata        = MDATA_TAG;
        c1Tx.data[31:0]       = 32'h1;
        c1Tx.data[63:32]      = code_q;
        c1Tx.data[127:64]     = data_q;
        c1Tx.data[191:128]    = snap_q;
        c1Tx.data[223:192]    = seq_q;
        c1Tx.valid            = valid_q;
    end

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign error   = error_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_sobel_dsm_writer.sv
// Testbench for sobel_dsm_writer: directed steps with randomized codes/payloads/bases,
// checked against a reference built from the status-line layout and protocol rules.
`timescale 1ns/1ps
module tb_sobel_dsm_writer;
    import ccip_if_pkg::*;

    localparam logic [15:0] TAG = 16'hD5A0;
    localparam int          TMO = 4096;

    logic           clk         = 1'b0;
    logic           reset       = 1'b1;
    t_hc_address    hc_dsm_base = '0;
    logic           report_req  = 1'b0;
    logic [31:0]    report_code = '0;
    logic [63:0]    report_data = '0;
    logic           c1TxAlmFull = 1'b0;
    t_if_ccip_c1_Rx c1Rx        = '0;
    t_if_ccip_c1_Tx c1Tx;
    logic           busy, done, error, overrun;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: cycle count since reset release, completed-report count.
    logic [63:0] ref_cnt;
    logic [31:0] exp_seq = '0;
    int          wr_seen   = 0;
    int          done_seen = 0;

    always #5 clk = ~clk;

    sobel_dsm_writer #(
        .MDATA_TAG  (TAG),
        .RSP_TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hc_dsm_base(hc_dsm_base),
        .report_req (report_req),
        .report_code(report_code),
        .report_data(report_data),
        .c1TxAlmFull(c1TxAlmFull),
        .c1Rx       (c1Rx),
        .c1Tx       (c1Tx),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .overrun    (overrun)
    );

    always @(posedge clk or posedge reset) begin
        if (reset) ref_cnt <= '0;
        else       ref_cnt <= ref_cnt + 64'd1;
    end

    always @(posedge clk) begin
        if (c1Tx.valid === 1'b1) wr_seen <= wr_seen + 1;
        if (done === 1'b1)       done_seen <= done_seen + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (observed hang, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_wide(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] ref_line(input logic [31:0] code, input logic [63:0] data,
                                              input logic [63:0] snap, input logic [31:0] seq);
        logic [511:0] l;
        l            = '0;
        l[31:0]      = 32'h1;
        l[63:32]     = code;
        l[127:64]    = data;
        l[191:128]   = snap;
        l[223:192]   = seq;
        return l;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        report_req  = 1'b0;
        c1TxAlmFull = 1'b0;
        c1Rx        = '0;
        tick();
        tick();
        reset   = 1'b0;
        exp_seq = '0;
    endtask

    task automatic drive_rsp(input t_ccip_c1_rsp t, input logic [15:0] m);
        c1Rx                = '0;
        c1Rx.rspValid       = 1'b1;
        c1Rx.hdr.resp_type  = t;
        c1Rx.hdr.mdata      = m;
        c1Rx.hdr.cl_num     = 2'($urandom_range(0, 3));
    endtask

    // Request one report; almfull is held high for 'stall' cycles starting with the
    // request cycle. Returns in the first cycle after the write was presented.
    task automatic issue(input t_hc_address base, input logic [31:0] code,
                         input logic [63:0] data, input int stall,
                         output logic [63:0] obs_snap);
        logic [63:0]        snap;
        t_ccip_c1_ReqMemHdr eh;
        hc_dsm_base = base;
        report_code = code;
        report_data = data;
        report_req  = 1'b1;
        c1TxAlmFull = (stall != 0);
        snap        = ref_cnt;
        tick();
        report_req  = 1'b0;
        report_code = $urandom;
        report_data = {$urandom, $urandom};
        hc_dsm_base = {$urandom, $urandom} | 64'h1;
        for (int i = 0; i < stall; i++) begin
            chk_bit("stall_valid", c1Tx.valid, 1'b0);
            chk_bit("stall_busy", busy, 1'b1);
            if (i == stall - 1) c1TxAlmFull = 1'b0;
            tick();
        end
        eh          = '0;
        eh.req_type = eREQ_WRLINE_I;
        eh.vc_sel   = eVC_VA;
        eh.cl_len   = eCL_LEN_1;
        eh.sop      = 1'b1;
        eh.address  = base[41:0];
        eh.mdata    = TAG;
        chk_bit("issue_valid", c1Tx.valid, 1'b1);
        chk_bit("issue_busy", busy, 1'b1);
        chk_wide("issue_hdr", 512'(c1Tx.hdr), 512'(eh));
        chk_wide("issue_data", c1Tx.data, ref_line(code, data, snap, exp_seq));
        obs_snap = c1Tx.data[191:128];
        tick();
        chk_bit("post_issue_valid", c1Tx.valid, 1'b0);
    endtask

    task automatic ack(input int delay);
        for (int i = 0; i < delay; i++) begin
            chk_bit("wait_no_done", done, 1'b0);
            tick();
        end
        drive_rsp(eRSP_WRLINE, TAG);
        tick();
        c1Rx = '0;
        chk_bit("done_pulse", done, 1'b1);
        chk_bit("done_busy", busy, 1'b1);
        exp_seq = exp_seq + 32'd1;
        tick();
        chk_bit("done_one_cycle", done, 1'b0);
        chk_bit("idle_busy", busy, 1'b0);
    endtask

    initial begin
        logic [63:0] s0, s1, s2;
        int          wr0, dn0;

        // Reset state
        do_reset();
        chk_bit("rst_valid", c1Tx.valid, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_done", done, 1'b0);
        chk_bit("rst_error", error, 1'b0);
        chk_bit("rst_overrun", overrun, 1'b0);

        // Basic report to 0x1000
        issue(64'h1000, 32'h5, 64'hCAFE, 0, s0);
        ack(2);
        chk_bit("basic_error", error, 1'b0);
        chk_bit("basic_overrun", overrun, 1'b0);

        // Three back-to-back reports: sequence 0,1,2 and rising snapshots
        do_reset();
        issue({$urandom, $urandom} | 64'h40, $urandom, {$urandom, $urandom}, 0, s0);
        ack(0);
        issue({$urandom, $urandom} | 64'h40, $urandom, {$urandom, $urandom}, 0, s1);
        ack(1);
        issue({$urandom, $urandom} | 64'h40, $urandom, {$urandom, $urandom}, 0, s2);
        ack($urandom_range(0, 5));
        chk_bit("snap_mono_01", s1 > s0, 1'b1);
        chk_bit("snap_mono_12", s2 > s1, 1'b1);

        // Back-pressure for 10 cycles
        issue(64'h2000, $urandom, {$urandom, $urandom}, 10, s0);
        ack($urandom_range(0, 5));
        chk_bit("bp_overrun", overrun, 1'b0);

        // report_req in the same cycle as the accepted response counts as overrun
        wr0 = wr_seen;
        issue(64'h3000, $urandom, {$urandom, $urandom}, 0, s0);
        drive_rsp(eRSP_WRLINE, TAG);
        report_req  = 1'b1;
        hc_dsm_base = 64'h4000;
        tick();
        c1Rx       = '0;
        report_req = 1'b0;
        chk_bit("same_cycle_done", done, 1'b1);
        chk_bit("same_cycle_overrun", overrun, 1'b1);
        exp_seq = exp_seq + 32'd1;
        tick();
        tick();
        tick();
        chk_bit("same_cycle_idle", busy, 1'b0);
        chk_int("same_cycle_writes", wr_seen - wr0, 1);

        // Overrun during WAIT_RSP, foreign responses ignored
        do_reset();
        wr0 = wr_seen;
        issue({$urandom, $urandom} | 64'h80, $urandom, {$urandom, $urandom}, 0, s0);
        tick();
        report_req  = 1'b1;
        report_code = $urandom;
        tick();
        report_req = 1'b0;
        chk_bit("ovr_flag", overrun, 1'b1);
        chk_bit("ovr_busy", busy, 1'b1);
        chk_bit("ovr_valid", c1Tx.valid, 1'b0);
        drive_rsp(eRSP_WRLINE, TAG ^ 16'h0001);
        tick();
        c1Rx = '0;
        chk_bit("bad_mdata_done", done, 1'b0);
        chk_bit("bad_mdata_busy", busy, 1'b1);
        drive_rsp(eRSP_WRFENCE, TAG);
        tick();
        c1Rx = '0;
        chk_bit("bad_type_done", done, 1'b0);
        chk_bit("bad_type_busy", busy, 1'b1);
        ack(1);
        chk_int("ovr_writes", wr_seen - wr0, 1);
        chk_bit("ovr_error", error, 1'b0);

        // Response in the last allowed cycle is accepted
        do_reset();
        issue(64'h5000, $urandom, {$urandom, $urandom}, 0, s0);
        ack(TMO - 1);
        chk_bit("edge_error", error, 1'b0);

        // Timeout: error, no done, sequence not advanced
        do_reset();
        dn0 = done_seen;
        issue(64'h6000, $urandom, {$urandom, $urandom}, 0, s0);
        for (int i = 0; i < TMO; i++) begin
            chk_bit("tmo_wait_error", error, 1'b0);
            tick();
        end
        chk_bit("tmo_error", error, 1'b1);
        chk_bit("tmo_busy", busy, 1'b0);
        chk_int("tmo_no_done", done_seen - dn0, 0);
        issue(64'h7000, $urandom, {$urandom, $urandom}, 0, s0);
        ack(2);

        // Null base: error, no write
        do_reset();
        wr0         = wr_seen;
        hc_dsm_base = '0;
        report_req  = 1'b1;
        tick();
        report_req = 1'b0;
        chk_bit("null_error", error, 1'b1);
        chk_bit("null_busy", busy, 1'b0);
        chk_bit("null_valid", c1Tx.valid, 1'b0);
        tick();
        tick();
        chk_int("null_writes", wr_seen - wr0, 0);

        // Async reset while waiting for a response, then a late response
        issue(64'h8000, $urandom, {$urandom, $urandom}, 0, s0);
        report_req = 1'b1;
        tick();
        report_req = 1'b0;
        chk_bit("pre_rst_overrun", overrun, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk_bit("async_rst_valid", c1Tx.valid, 1'b0);
        chk_bit("async_rst_busy", busy, 1'b0);
        chk_bit("async_rst_done", done, 1'b0);
        chk_bit("async_rst_error", error, 1'b0);
        chk_bit("async_rst_overrun", overrun, 1'b0);
        tick();
        reset = 1'b0;
        dn0   = done_seen;
        drive_rsp(eRSP_WRLINE, TAG);
        tick();
        c1Rx = '0;
        chk_bit("late_rsp_done", done, 1'b0);
        tick();
        chk_bit("late_rsp_busy", busy, 1'b0);
        chk_int("late_rsp_no_done", done_seen - dn0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sobel_dsm_writer.md
SOBEL_DSM_WRITER -- requirements
Module: sobel_dsm_writer

Interface
REQ-001 SHALL have parameter MDATA_TAG, default 16'hD5A0, the fixed mdata value carried by every DSM write request.
REQ-002 SHALL have parameter RSP_TIMEOUT, default 4096, the maximum cycles to wait for a write response before flagging an error.
REQ-003 SHALL have port clk, input, 1, the single clock for the block.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port hc_dsm_base, input, t_hc_address, the DSM cache-line address programmed by host software.
REQ-006 SHALL have port report_req, input, 1, a single-cycle request to write one status line.
REQ-007 SHALL have port report_code, input, 32, the status code sampled with report_req.
REQ-008 SHALL have port report_data, input, 64, the status payload sampled with report_req.
REQ-009 SHALL have port c1TxAlmFull, input, 1, CCI-P channel-1 almost-full back-pressure.
REQ-010 SHALL have port c1Rx, input, t_if_ccip_c1_Rx, the CCI-P channel-1 response channel.
REQ-011 SHALL have port c1Tx, output, t_if_ccip_c1_Tx, the CCI-P channel-1 write request channel.
REQ-012 SHALL have port busy, output, 1, high while a report is in flight.
REQ-013 SHALL have port done, output, 1, a one-cycle pulse when a report write has been acknowledged.
REQ-014 SHALL have port error, output, 1, sticky timeout or null-base error flag.
REQ-015 SHALL have port overrun, output, 1, sticky flag for a report_req dropped while busy.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT_RSP and DONE.
REQ-017 SHALL run a free-running 64-bit cycle counter from reset release, wrapping at 2^64.
REQ-018 SHALL, in IDLE on report_req with hc_dsm_base != 0, latch report_code, report_data, hc_dsm_base and a counter snapshot, then move to ISSUE.
REQ-019 SHALL, in IDLE on report_req with hc_dsm_base == 0, set error, issue no write and stay in IDLE.
REQ-020 SHALL, in ISSUE while c1TxAlmFull=1, hold c1Tx.valid=0 and remain in ISSUE.
REQ-021 SHALL, in ISSUE while c1TxAlmFull=0, drive c1Tx.valid=1 for exactly one cycle, then move to WAIT_RSP.
REQ-022 SHALL assert registered c1Tx.valid no earlier than the cycle after report_req is sampled (latency 1 cycle when not back-pressured).
REQ-023 SHALL drive the request header as: req_type eREQ_WRLINE_I, vc_sel eVC_VA, cl_len eCL_LEN_1, sop 1, address = latched base bits [41:0], mdata = MDATA_TAG.
REQ-024 SHALL format the 512-bit write data as:
  - [31:0] = 32'h1 (complete flag)
  - [63:32] = report_code
  - [127:64] = report_data
  - [191:128] = counter snapshot
  - [223:192] = sequence number
  - all remaining bits zero
REQ-025 SHALL, in WAIT_RSP, accept only c1Rx.rspValid with resp_type eRSP_WRLINE and mdata == MDATA_TAG; all other responses SHALL be ignored.
REQ-026 SHALL, on an accepted response, move to DONE, pulse done for one cycle, increment the 32-bit sequence number (wrapping) and return to IDLE.
REQ-027 SHALL, if WAIT_RSP lasts RSP_TIMEOUT cycles without an accepted response, set error and return to IDLE without pulsing done or incrementing the sequence number.
REQ-028 SHALL assert busy in ISSUE, WAIT_RSP and DONE, and deassert it in IDLE.
REQ-029 SHALL, on report_req while not in IDLE, drop the request, set overrun and leave the in-flight report unaffected.
REQ-030 SHALL, when report_req arrives in the same cycle as the accepted response, treat it as overrun (FSM not yet in IDLE).
REQ-031 SHALL, when a response arrives in the same cycle the timeout count is reached, accept the response: done pulses and error is not set.
REQ-032 SHALL hold c1Tx.valid=0 at all times outside the single ISSUE issue cycle.

Reset
REQ-033 SHALL, on reset assertion (asynchronous, including mid-transaction), force the FSM to IDLE and clear the counter, sequence number, latched fields, c1Tx.valid, busy, done, error and overrun to 0.
REQ-034 SHALL, after reset, ignore any late response to a request issued before reset.

Verification
REQ-035 SHALL cover: base=0x1000, report_req with code=0x5, data=0xCAFE, almfull=0 -> one WRLINE_I to address 0x1000 one cycle later with [63:32]=5, [127:64]=0xCAFE, [223:192]=0; matching rsp -> done pulse, busy low.
REQ-036 SHALL cover: almfull held high for 10 cycles after report_req -> c1Tx.valid stays 0 during those cycles, then one valid cycle after almfull drops.
REQ-037 SHALL cover: no response for 4096 cycles -> error=1, done never pulses, next report carries sequence 0.
REQ-038 SHALL cover: a second report_req during WAIT_RSP -> overrun=1, exactly one write issued, a response with mdata != MDATA_TAG ignored.
REQ-039 SHALL cover: base=0 with report_req -> error=1, no c1Tx.valid; reset asserted in WAIT_RSP -> all outputs 0 immediately.
REQ-040 SHALL cover: three back-to-back completed reports -> sequence numbers 0, 1, 2 with monotonically increasing counter snapshots.
